// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - host-side bundle for the bit-serial adder sequencer
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, op_a, op_b, cin, abort,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, op_a, op_b, cin, abort,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - LSB-first bit-serial add/subtract using one full-adder cell
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;
    logic last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c     = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        last_bit = (cnt_q == CW'(WIDTH - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort outranks the final bit: results stay untouched
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    part_d  = {fa_s, part_q[WIDTH-1:1]};
                    carry_d = fa_c;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB
                        sum_d   = {fa_s, part_q[WIDTH-1:1]};
                        cout_d  = fa_c;
                        ovf_d   = carry_q ^ fa_c;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
